// File: rtl/io_port_ctrl_pkg.sv
// io_pkg: shared states, default widths and bus direction encoding for io_port_ctrl.
package io_pkg;

    localparam int DW_DEF      = 16;
    localparam int AW_DEF      = 2;
    localparam int TIMEOUT_DEF = 255;

    // ext_rw encoding seen by the device
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } io_state_e;

endpackage

// File: rtl/io_port_ctrl_timeout_cnt.sv
// io_timeout_cnt: per-phase watchdog. Loads MAX-1 on clear, counts down while
// enabled, and flags terminal count in the MAX-th enabled cycle after a clear.
module io_timeout_cnt #(
    parameter int MAX = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(MAX + 1);
    localparam logic [CW-1:0] LOAD = CW'(MAX - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // next count: reload on clear, decrement while enabled, stick at zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = LOAD;
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    // count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= LOAD;
        else       cnt_q <= cnt_d;
    end

    assign tc_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: single-outstanding IN/OUT port controller running a 4-phase
// strobe/ack handshake. Optional per-phase watchdog under `IO_TIMEOUT_EN.
module io_port_ctrl
    import io_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rd_req,
    input  logic          wr_req,
    input  logic [AW-1:0] port_addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          oe,
    output logic [DW-1:0] bus_out,
    input  logic [DW-1:0] bus_in,
    output logic [AW-1:0] ext_addr,
    output logic          ext_rw,
    output logic          ext_strobe,
    input  logic          ext_ack
);

    io_state_e     state_q, state_d;
    logic [AW-1:0] addr_q;
    logic          rw_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rd_data_q;
    logic          err_q;
    logic          accept;
    logic          tc;
    logic          timeout_hit;

    assign accept = (state_q == IDLE) && (rd_req || wr_req);

`ifdef IO_TIMEOUT_EN
    logic cnt_en;
    assign cnt_en = (state_q == STROBE) || (state_q == RELEASE);

    io_timeout_cnt #(.MAX(TIMEOUT)) u_tmo (
        .clk   (clk),
        .reset (reset),
        .clr_i (state_d != state_q),
        .en_i  (cnt_en),
        .tc_o  (tc)
    );

    // error flag: set when a phase expires, cleared by the next accepted request
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            err_q <= 1'b0;
        else if (accept)      err_q <= 1'b0;
        else if (timeout_hit) err_q <= 1'b1;
    end
`else
    assign tc    = 1'b0;
    assign err_q = 1'b0;
`endif

    // an ack arriving in the terminal cycle still wins over the timeout
    assign timeout_hit = tc && (((state_q == STROBE) && !ext_ack) ||
                                ((state_q == RELEASE) && ext_ack));

    // next-state logic for the handshake sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = STROBE;
            STROBE:  if (ext_ack) state_d = RELEASE;
                     else if (timeout_hit) state_d = DONE;
            RELEASE: if (!ext_ack) state_d = DONE;
                     else if (timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // request latch (write wins on a double request) and read-data capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            rw_q      <= RW_READ;
            wdata_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= port_addr;
                rw_q    <= wr_req ? RW_WRITE : RW_READ;
                wdata_q <= wr_data;
            end
            if (state_q == STROBE && rw_q == RW_READ) begin
                if (ext_ack)          rd_data_q <= bus_in;
                else if (timeout_hit) rd_data_q <= '1;
            end
        end
    end

    assign busy       = ((state_q != IDLE) && (state_q != DONE)) || accept;
    assign done       = (state_q == DONE);
    assign err        = err_q;
    assign ext_strobe = (state_q == STROBE);
    // oe only for writes, so the device never fights us during a read
    assign oe         = (rw_q == RW_WRITE) &&
                        ((state_q == SETUP) || (state_q == STROBE) || (state_q == RELEASE));
    assign bus_out    = wdata_q;
    assign ext_addr   = addr_q;
    assign ext_rw     = rw_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: randomized scoreboard bench with a behavioural device model.
module tb_io_port_ctrl;

    logic        clk, reset, rd_req, wr_req, oe, busy, done, err, ext_rw, ext_strobe, ext_ack;
    logic [1:0]  port_addr, ext_addr;
    logic [15:0] wr_data, rd_data, bus_out, bus_in;

    io_port_ctrl #(.DW(16), .AW(2), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req),
        .port_addr(port_addr), .wr_data(wr_data), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err), .oe(oe), .bus_out(bus_out),
        .bus_in(bus_in), .ext_addr(ext_addr), .ext_rw(ext_rw),
        .ext_strobe(ext_strobe), .ext_ack(ext_ack)
    );

    typedef struct {
        logic [15:0] rd;
        logic        err;
        int          cyc;
        int          oe_cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, errors = 0, cyc = 0;
    int          dev_a = 1, dev_r = 1;
    logic [15:0] dev_d = '0;
    logic [15:0] ref_rd = '0;
    logic        cur_wr = 1'b0;
    logic [1:0]  cur_addr = '0;
    logic [15:0] cur_data = '0;

    initial begin clk = 1'b0; forever #5 clk = ~clk; end
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // device: acks dev_a cycles after strobe rises, releases dev_r cycles after it falls
    initial begin
        int hi = 0, lo = 0;
        ext_ack = 1'b0; bus_in = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ext_ack = 1'b0; hi = 0; lo = 0;
            end else if (ext_strobe) begin
                hi++; lo = 0;
                if (hi >= dev_a + 1) begin ext_ack = 1'b1; bus_in = dev_d; end
                else if (!ext_ack) bus_in = 16'($urandom);
            end else begin
                hi = 0;
                if (ext_ack) begin
                    lo++;
                    if (lo >= dev_r + 1) begin ext_ack = 1'b0; lo = 0; end
                end
            end
        end
    end

    // monitor: pops the scoreboard on every done pulse, checks bus drive cycles
    initial begin
        int   oe_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset) oe_cnt = 0;
            else if (done) begin
                if (sb.size() == 0) chk("spurious_done", 32'(done), 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(e.rd));
                    chk("err", 32'(err), 32'(e.err));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("oe_cycles", 32'(oe_cnt), 32'(e.oe_cnt));
                    chk("done_busy", 32'(busy), 32'd0);
                    chk("done_oe", 32'(oe), 32'd0);
                end
                oe_cnt = 0;
            end else if (oe) begin
                oe_cnt++;
                chk("oe_rw", 32'(ext_rw), 32'd1);
                chk("bus_out", 32'(bus_out), 32'(cur_data));
                chk("oe_addr", 32'(ext_addr), 32'(cur_addr));
            end else if (ext_strobe) begin
                chk("strobe_addr", 32'(ext_addr), 32'(cur_addr));
                chk("strobe_rw", 32'(ext_rw), 32'(cur_wr));
            end
        end
    end

    // reference: done arrives 4+a+r cycles after the request, oe spans SETUP..RELEASE
    task automatic push_exp(input logic wr, input int a, input int r, input logic [15:0] dd, input int c0);
        exp_t e;
        if (!wr) ref_rd = dd;
        e.rd = ref_rd; e.err = 1'b0; e.cyc = c0 + 4 + a + r;
        e.oe_cnt = wr ? (a + r + 3) : 0;
        sb.push_back(e);
    endtask

    task automatic set_dev(input logic wr, input logic [1:0] addr, input logic [15:0] data,
                           input int a, input int r, input logic [15:0] dd);
        dev_a = a; dev_r = r; dev_d = dd;
        cur_wr = wr; cur_addr = addr; cur_data = data;
    endtask

    task automatic start_xfer(input logic wr, input logic rd, input logic [1:0] addr,
                              input logic [15:0] data, input int a, input int r,
                              input logic [15:0] dd, input bit push, output int c0);
        @(negedge clk);
        set_dev(wr, addr, data, a, r, dd);
        wr_req = wr; rd_req = rd; port_addr = addr; wr_data = data;
        c0 = cyc;
        if (push) push_exp(wr, a, r, dd, c0);
        #1 chk("req_busy", 32'(busy), 32'd1);
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0;
        port_addr = 2'($urandom); wr_data = 16'($urandom);
        #1 chk("setup_err_clear", 32'(err), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        ref_rd = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
        #3;
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            do_reset();
        end
    endtask

    initial begin
        int c0, a, r, n;
        logic wr, rd;
        reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0; port_addr = '0; wr_data = '0;
        #1;
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_oe", 32'(oe), 32'd0);
        chk("rst_strobe", 32'(ext_strobe), 32'd0);
        chk("rst_rw", 32'(ext_rw), 32'd0);
        chk("rst_addr", 32'(ext_addr), 32'd0);
        chk("rst_bus_out", 32'(bus_out), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // directed: write, read, simultaneous request
        start_xfer(1'b1, 1'b0, 2'd2, 16'hA5C3, 1, 1, 16'h0000, 1'b1, c0); wait_drain();
        start_xfer(1'b0, 1'b1, 2'd1, 16'h0000, 3, 1, 16'h1234, 1'b1, c0); wait_drain();
        start_xfer(1'b1, 1'b1, 2'd3, 16'h00FF, 1, 2, 16'hDEAD, 1'b1, c0); wait_drain();

        // reset in STROBE: handshake abandoned, no done
        start_xfer(1'b1, 1'b0, 2'd2, 16'h5A5A, 3, 1, 16'h0000, 1'b0, c0);
        @(negedge clk);
        chk("pre_rst_strobe", 32'(ext_strobe), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_strobe", 32'(ext_strobe), 32'd0);
        chk("mid_rst_oe", 32'(oe), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rd", 32'(rd_data), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0; ref_rd = '0;
        start_xfer(1'b0, 1'b1, 2'd0, 16'h0000, 1, 1, 16'hBEEF, 1'b1, c0); wait_drain();

        // back-to-back: request during DONE ignored, taken in the following IDLE
        start_xfer(1'b1, 1'b0, 2'd1, 16'h1111, 2, 1, 16'h0000, 1'b1, c0);
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        chk("btb_saw_done", 32'(done), 32'd1);
        set_dev(1'b1, 2'd3, 16'h2222, 1, 1, 16'h0000);
        wr_req = 1'b1; port_addr = 2'd3; wr_data = 16'h2222;
        #1 chk("btb_done_busy", 32'(busy), 32'd0);
        @(negedge clk);
        c0 = cyc;
        push_exp(1'b1, 1, 1, 16'h0000, c0);
        #1 chk("btb_idle_busy", 32'(busy), 32'd1);
        @(negedge clk);
        wr_req = 1'b0;
        wait_drain();

        // randomized transfers
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom); rd = 1'($urandom);
            if (!wr && !rd) rd = 1'b1;
            a = int'($urandom_range(1, 4)); r = int'($urandom_range(1, 4));
            start_xfer(wr, rd, 2'($urandom), 16'($urandom), a, r, 16'($urandom), 1'b1, c0);
            wait_drain();
        end

        // device never acks
`ifdef IO_TIMEOUT_EN
        begin
            exp_t e;
            start_xfer(1'b0, 1'b1, 2'd2, 16'h0000, 1000000, 1, 16'h0000, 1'b0, c0);
            ref_rd = 16'hFFFF;
            e.rd = 16'hFFFF; e.err = 1'b1; e.cyc = c0 + 10; e.oe_cnt = 0;
            sb.push_back(e);
            wait_drain();
            start_xfer(1'b1, 1'b0, 2'd1, 16'hC0DE, 1, 1, 16'h0000, 1'b1, c0);
            wait_drain();
        end
`else
        begin
            int low = 0;
            start_xfer(1'b0, 1'b1, 2'd2, 16'h0000, 1000000, 1, 16'h0000, 1'b0, c0);
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (busy !== 1'b1) low++;
            end
            chk("hang_busy_low_cycles", 32'(low), 32'd0);
            do_reset();
            start_xfer(1'b1, 1'b0, 2'd1, 16'hC0DE, 1, 1, 16'h0000, 1'b1, c0);
            wait_drain();
        end
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
